// File: rtl/instr_encoder.sv
// instr_encoder: packs an opcode and a signed 8-bit immediate into an 8-bit
// instruction word (imm4 or imm2+register formats). Accepted words stream out
// with sequential program-memory addresses through one output register stage.
// Entries whose immediate cannot be represented are consumed, dropped and counted.
module instr_encoder #(
  parameter int ADDR_W = 8,
  parameter int ERR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        opcode,
  input  logic [7:0]        imm8,
  input  logic              isim4,
  input  logic [1:0]        reg_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic              out_valid_q, out_valid_d;
  logic [7:0]        out_inst_q,  out_inst_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic              err_q,       err_d;
  logic [ERR_W-1:0]  err_cnt_q,   err_cnt_d;

  logic       imm_legal;
  logic [7:0] enc_word;
  logic       in_ready_c;
  logic       accept;
  logic       legal_acc;
  logic       bad_acc;

  // Encode the entry, check its immediate range and form the input handshake.
  always_comb begin
    // The immediate is representable when every bit above the field's sign
    // bit equals that sign bit, so sign-extending the field restores imm8.
    if (isim4) begin
      imm_legal = (&imm8[7:3]) | ~(|imm8[7:3]);
      enc_word  = {opcode, imm8[3:0]};
    end else begin
      imm_legal = (&imm8[7:1]) | ~(|imm8[7:1]);
      enc_word  = {opcode, reg_sel, imm8[1:0]};
    end
    // A restart takes priority over data, so nothing is accepted in that cycle.
    in_ready_c = (state_q == ST_LOAD) && !start && (!out_valid_q || out_ready);
    accept     = in_valid && in_ready_c;
    legal_acc  = accept && imm_legal;
    bad_acc    = accept && !imm_legal;
  end

  // Next-state logic for the FSM, address counter, output stage and error state.
  always_comb begin
    // NOTE: every signal starts from its held value so no path leaves one
    // unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    // Output register: a new legal word may replace the one leaving this cycle.
    if (legal_acc) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_word;
      out_addr_d  = wr_addr_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // The address never wraps: the last slot parks the encoder in FULL.
    if (legal_acc) begin
      if (wr_addr_q == LAST_ADDR) begin
        state_d = ST_FULL;
      end else begin
        wr_addr_d = wr_addr_q + ADDR_W'(1);
      end
    end

    if (bad_acc) begin
      err_d = 1'b1;
      if (err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + ERR_W'(1);
      end
    end

    // start (re)opens loading from address 0 with clean error state in any
    // state; a pending output word is left to drain normally.
    if (start) begin
      state_d   = ST_LOAD;
      wr_addr_d = '0;
      err_d     = 1'b0;
      err_cnt_d = '0;
    end
  end

  // State registers with synchronous reset; reset discards any pending word.
  always_ff @(posedge clk) begin
    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign full      = (state_q == ST_FULL);
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder, built with a small memory (ADDR_W=3) and a narrow
// error counter (ERR_W=2) so fill-to-full and counter saturation are reachable.
module tb_instr_encoder;

  localparam int ADDR_W = 3;
  localparam int ERR_W  = 2;
  localparam int ERR_MAX = 3;

  typedef struct {
    logic [3:0] op;
    logic [7:0] imm;
    logic       i4;
    logic [1:0] rs;
    logic       legal;
    logic [7:0] inst;
  } vec_t;

  typedef struct {
    logic [7:0]        inst;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [7:0]        imm8;
  logic              isim4;
  logic [1:0]        reg_sel;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              full;
  logic              err;
  logic [ERR_W-1:0]  err_cnt;

  instr_encoder #(.ADDR_W(ADDR_W), .ERR_W(ERR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .imm8      (imm8),
    .isim4     (isim4),
    .reg_sel   (reg_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_addr  (out_addr),
    .full      (full),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];
  logic [ADDR_W-1:0] m_addr;
  logic              m_err;
  int                m_cnt;
  logic              cur_legal;
  logic [7:0]        cur_inst;
  bit                last_fire;

  vec_t tbl[10];
  vec_t v_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    in_valid  = 1'b1;
    opcode    = v.op;
    imm8      = v.imm;
    isim4     = v.i4;
    reg_sel   = v.rs;
    cur_legal = v.legal;
    cur_inst  = v.inst;
  endtask

  // One clock: sample handshakes on the falling edge, update the scoreboard
  // and reference counters, then return just after the rising edge.
  task automatic step(output bit acc);
    exp_t e;
    @(negedge clk);
    acc       = in_valid && in_ready;
    last_fire = out_valid && out_ready;
    if (rst) begin
      sb.delete();
      m_addr = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
      acc    = 1'b0;
    end else begin
      if (last_fire) begin
        if (sb.size() == 0) begin
          check("unexpected_out", {24'h0, out_inst}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("out_inst", {24'h0, out_inst}, {24'h0, e.inst});
          check("out_addr", {29'h0, out_addr}, {29'h0, e.addr});
        end
      end
      if (acc && cur_legal) begin
        sb.push_back('{inst: cur_inst, addr: m_addr});
        m_addr = m_addr + 3'd1;
      end
      if (acc && !cur_legal) begin
        m_err = 1'b1;
        if (m_cnt < ERR_MAX) m_cnt++;
      end
      if (start) begin
        m_addr = '0;
        m_err  = 1'b0;
        m_cnt  = 0;
      end
    end
    @(posedge clk);
    #1;
    if (acc && cur_legal) check("latency_out_valid", {31'h0, out_valid}, 32'h1);
  endtask

  task automatic send(input vec_t v);
    bit got;
    got = 1'b0;
    apply(v);
    for (int n = 0; n < 20 && !got; n++) step(got);
    if (!got) check("accept_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bit acc;
    start = 1'b1;
    step(acc);
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int fires;
    int accepted;

    tbl[0] = '{op: 4'hA, imm: 8'hFD, i4: 1'b1, rs: 2'b00, legal: 1'b1, inst: 8'hAD};
    tbl[1] = '{op: 4'h3, imm: 8'hFF, i4: 1'b0, rs: 2'b10, legal: 1'b1, inst: 8'h3B};
    tbl[2] = '{op: 4'h3, imm: 8'h02, i4: 1'b0, rs: 2'b10, legal: 1'b0, inst: 8'h00};
    tbl[3] = '{op: 4'h5, imm: 8'h07, i4: 1'b1, rs: 2'b00, legal: 1'b1, inst: 8'h57};
    tbl[4] = '{op: 4'h6, imm: 8'hF8, i4: 1'b1, rs: 2'b00, legal: 1'b1, inst: 8'h68};
    tbl[5] = '{op: 4'h7, imm: 8'h08, i4: 1'b1, rs: 2'b00, legal: 1'b0, inst: 8'h00};
    tbl[6] = '{op: 4'h1, imm: 8'h01, i4: 1'b0, rs: 2'b01, legal: 1'b1, inst: 8'h15};
    tbl[7] = '{op: 4'h2, imm: 8'hFE, i4: 1'b0, rs: 2'b11, legal: 1'b1, inst: 8'h2E};
    tbl[8] = '{op: 4'hF, imm: 8'hF7, i4: 1'b1, rs: 2'b00, legal: 1'b0, inst: 8'h00};
    tbl[9] = '{op: 4'h0, imm: 8'hFE, i4: 1'b0, rs: 2'b00, legal: 1'b1, inst: 8'h02};
    v_bad  = '{op: 4'h4, imm: 8'h10, i4: 1'b1, rs: 2'b00, legal: 1'b0, inst: 8'h00};

    m_addr = '0; m_err = 1'b0; m_cnt = 0; last_fire = 1'b0;
    cur_legal = 1'b0; cur_inst = '0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; imm8 = '0; isim4 = 1'b0; reg_sel = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b1;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_inst",  {24'h0, out_inst},  32'h0);
    check("rst_out_addr",  {29'h0, out_addr},  32'h0);
    check("rst_full",      {31'h0, full},      32'h0);
    check("rst_err",       {31'h0, err},       32'h0);
    check("rst_err_cnt",   {30'h0, err_cnt},   32'h0);
    check("rst_in_ready",  {31'h0, in_ready},  32'h0);
    rst = 1'b0;
    apply(tbl[0]);
    step(acc);
    check("idle_no_accept", {31'h0, acc}, 32'h0);

    // Leave IDLE, then a start in LOAD with an entry present must not accept it.
    in_valid = 1'b0;
    pulse_start();
    apply(tbl[0]);
    start = 1'b1;
    step(acc);
    start = 1'b0;
    check("start_blocks_accept", {31'h0, acc}, 32'h0);
    in_valid = 1'b0;

    // Table-driven encode / range check with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(tbl[i]);
      check("err",     {31'h0, err},     {31'h0, m_err});
      check("err_cnt", {30'h0, err_cnt}, m_cnt);
    end
    repeat (3) step(acc);
    check("table_drained", sb.size(), 0);
    check("table_full",    {31'h0, full}, 32'h0);

    // Back-pressure: one accept, then the output holds while the sink stalls.
    pulse_start();
    out_ready = 1'b0;
    apply(tbl[3]);
    step(acc);
    check("bp_first_accept", {31'h0, acc}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_in_ready",  {31'h0, in_ready},  32'h0);
      check("bp_out_valid", {31'h0, out_valid}, 32'h1);
      check("bp_out_inst",  {24'h0, out_inst},  32'h57);
      check("bp_out_addr",  {29'h0, out_addr},  32'h0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    fires = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) in_valid = 1'b0;
      step(acc);
      if (last_fire) fires++;
    end
    check("bp_back_to_back", fires, 3);
    check("bp_drained", sb.size(), 0);

    // Fill all 2**ADDR_W addresses, reach FULL, then restart at address 0.
    pulse_start();
    apply(tbl[4]);
    accepted = 0;
    for (int n = 0; n < 40 && accepted < 8; n++) begin
      step(acc);
      if (acc) accepted++;
    end
    check("fill_accepted", accepted, 8);
    check("fill_full",     {31'h0, full},     32'h1);
    check("fill_in_ready", {31'h0, in_ready}, 32'h0);
    step(acc);
    check("full_no_accept", {31'h0, acc}, 32'h0);
    in_valid = 1'b0;
    step(acc);
    check("fill_drained", sb.size(), 0);
    pulse_start();
    check("restart_full", {31'h0, full}, 32'h0);
    send(tbl[0]);
    repeat (2) step(acc);
    check("restart_drained", sb.size(), 0);

    // Error saturation: five illegal imm4 entries, no output words.
    pulse_start();
    for (int k = 0; k < 5; k++) send(v_bad);
    repeat (2) step(acc);
    check("sat_err_cnt",   {30'h0, err_cnt},   32'h3);
    check("sat_err",       {31'h0, err},       32'h1);
    check("sat_out_valid", {31'h0, out_valid}, 32'h0);

    // Reset while a word is pending and the sink is stalled.
    pulse_start();
    out_ready = 1'b0;
    send(tbl[1]);
    check("mid_pending", {31'h0, out_valid}, 32'h1);
    rst = 1'b1;
    step(acc);
    rst = 1'b0;
    check("mid_out_valid", {31'h0, out_valid}, 32'h0);
    check("mid_out_addr",  {29'h0, out_addr},  32'h0);
    check("mid_err_cnt",   {30'h0, err_cnt},   32'h0);
    apply(tbl[0]);
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check("mid_idle_no_accept", {31'h0, acc}, 32'h0);
    end
    in_valid = 1'b0;
    pulse_start();
    apply(tbl[0]);
    #1;
    check("mid_restart_in_ready", {31'h0, in_ready}, 32'h1);
    send(tbl[0]);
    out_ready = 1'b1;
    repeat (2) step(acc);
    check("mid_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
